pipe_stimulus_player: RTL and testbench

Host-to-DAC stimulus playback block: the transmit-side counterpart to the ADC capture path. The host loads a waveform of DAC codes through an okPipeIn endpoint into an internal circular buffer. On command, the block replays the buffer to the DAC at a programmable sample rate, either once or looped. It sits in the ti_clk domain between the FrontPanel pipe-in/wire-in endpoints and the DAC code pins of the device under test.

---
 rtl/pipe_stimulus_player.sv | 208 ++++++++++++++++++++
 tb/tb_pipe_stimulus_player.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stimulus_player.sv
// pipe_stimulus_player: host-loaded DAC waveform buffer with paced one-shot or
// looped playback. Words arrive on the pipe-in strobe while idle. A start
// command replays them at one code every clk_div+1 cycles.
module pipe_stimulus_player #(
  parameter int PRECISION  = 10,
  parameter int DEPTH_LOG2 = 10,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [15:0]           wr_data,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  loop_en,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  output logic [PRECISION-1:0]  dac_code,
  output logic                  dac_strobe,
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   buf_count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Full count is exactly DEPTH, i.e. only the top bit of the counter set.
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state_reg, state_next;

  logic [DEPTH_LOG2-1:0]  wr_ptr_reg;
  logic [DEPTH_LOG2:0]    count_reg;
  logic                   overflow_reg;

  logic [DEPTH_LOG2-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_LOG2:0]    len_reg;
  logic [DIV_WIDTH-1:0]   period_reg;
  logic [DIV_WIDTH-1:0]   div_cnt_reg, div_cnt_next;
  logic                   drain_reg;

  logic [PRECISION-1:0]   dac_code_reg;
  logic                   strobe_reg;

  // Waveform storage plus a one-word bypass for a write landing in the
  // address being read on the same edge (write together with start).
  logic [PRECISION-1:0]   mem [DEPTH];
  logic [PRECISION-1:0]   ram_q_reg;
  logic                   byp_reg;
  logic [PRECISION-1:0]   byp_data_reg;
  logic [PRECISION-1:0]   rd_data;

  logic                   is_idle;
  logic                   has_room;
  logic                   wr_accept;
  logic                   wr_reject;
  logic [DEPTH_LOG2:0]    len_at_start;
  logic                   start_accept;
  logic                   fire;
  logic                   last_sample;
  logic                   unused_wr_hi;

  // Upper pipe-in bits carry nothing for narrow DACs.
  assign unused_wr_hi = ^wr_data;

  assign is_idle      = (state_reg == ST_IDLE);
  assign has_room     = (count_reg != FULL_CNT);
  assign wr_accept    = wr_en && !clear && is_idle && has_room;
  assign wr_reject    = wr_en && !clear && !(is_idle && has_room);
  assign len_at_start = count_reg + (wr_accept ? CNT_ONE : '0);
  assign start_accept = start && !clear && is_idle && (len_at_start != '0);

  // A sample goes out when the divider has expired, unless the pass is
  // draining or a stop/clear is arriving on this very edge.
  assign fire         = (state_reg == ST_PLAY) && !drain_reg && (div_cnt_reg == '0)
                        && !stop && !clear;
  assign last_sample  = ({1'b0, rd_ptr_reg} == (len_reg - CNT_ONE));
  assign rd_data      = byp_reg ? byp_data_reg : ram_q_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: clear wins, stop aborts silently, drain leads to DONE.
  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state_reg)
        ST_IDLE: if (start_accept) state_next = ST_PLAY;
        ST_PLAY: begin
          if (stop)           state_next = ST_IDLE;
          else if (drain_reg) state_next = ST_DONE;
        end
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Read pointer and divider advance: restart on start, reload on each sample.
  always_comb begin
    rd_ptr_next  = rd_ptr_reg;
    div_cnt_next = div_cnt_reg;
    if (start_accept) begin
      rd_ptr_next  = '0;
      div_cnt_next = '0;
    end else if (fire) begin
      rd_ptr_next  = last_sample ? '0 : rd_ptr_reg + PTR_ONE;
      div_cnt_next = period_reg;
    end else if (div_cnt_reg != '0) begin
      div_cnt_next = div_cnt_reg - DIV_ONE;
    end
  end

  // Buffer RAM: write port from the pipe, registered read at the next pointer.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= wr_data[PRECISION-1:0];
    end
    ram_q_reg <= mem[rd_ptr_next];
  end

  // Write-through capture so a word loaded alongside start is replayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_reg      <= 1'b0;
      byp_data_reg <= '0;
    end else begin
      byp_reg      <= wr_accept && (wr_ptr_reg == rd_ptr_next);
      byp_data_reg <= wr_data[PRECISION-1:0];
    end
  end

  // Load bookkeeping: write pointer, fill count and sticky reject flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (clear) begin
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        count_reg  <= count_reg + CNT_ONE;
      end
      if (wr_reject) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Playback datapath: latch pass parameters, pace samples, drive the DAC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg   <= '0;
      len_reg      <= '0;
      period_reg   <= '0;
      div_cnt_reg  <= '0;
      drain_reg    <= 1'b0;
      dac_code_reg <= '0;
      strobe_reg   <= 1'b0;
    end else begin
      rd_ptr_reg  <= rd_ptr_next;
      div_cnt_reg <= div_cnt_next;
      strobe_reg  <= fire;
      if (fire) begin
        dac_code_reg <= rd_data;
      end
      if (start_accept) begin
        period_reg <= clk_div;
        len_reg    <= len_at_start;
      end
      if (state_next != ST_PLAY) begin
        drain_reg <= 1'b0;
      end else if (fire && last_sample && !loop_en) begin
        drain_reg <= 1'b1;
      end
    end
  end

  assign dac_code   = dac_code_reg;
  assign dac_strobe = strobe_reg;
  assign busy       = (state_reg == ST_PLAY);
  assign done       = (state_reg == ST_DONE);
  assign buf_count  = count_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_pipe_stimulus_player.sv
// tb_pipe_stimulus_player: randomized playback checked against a timing and
// content model derived directly from the sample-schedule rules.
module tb_pipe_stimulus_player;

  localparam int P     = 10;
  localparam int DL    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [15:0]   wr_data = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          clear = 1'b0;
  logic          loop_en = 1'b0;
  logic [DW-1:0] clk_div = '0;
  logic [P-1:0]  dac_code;
  logic          dac_strobe;
  logic          busy;
  logic          done;
  logic [DL:0]   buf_count;
  logic          overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Observed events, stamped with the cycle number in which they are visible.
  int s_cyc[$];
  int s_code[$];
  int d_cyc[$];

  // Reference model of buffer contents and load state.
  int m_mem[DEPTH];
  int m_count = 0;
  int m_wr = 0;
  int m_ovf = 0;

  pipe_stimulus_player #(.PRECISION(P), .DEPTH_LOG2(DL), .DIV_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .start(start), .stop(stop), .clear(clear), .loop_en(loop_en),
    .clk_div(clk_div), .dac_code(dac_code), .dac_strobe(dac_strobe),
    .busy(busy), .done(done), .buf_count(buf_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dac_strobe) begin
        s_cyc.push_back(cyc + 1);
        s_code.push_back(int'(dac_code));
      end
      if (done) d_cyc.push_back(cyc + 1);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_store(input int d);
    if (m_count < DEPTH) begin
      m_mem[m_wr] = d % (1 << P);
      m_wr = (m_wr + 1) % DEPTH;
      m_count++;
    end else begin
      m_ovf = 1;
    end
  endtask

  task automatic write_word(input int d);
    wr_en = 1'b1;
    wr_data = d[15:0];
    step();
    wr_en = 1'b0;
    model_store(d);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    m_count = 0;
    m_wr = 0;
    m_ovf = 0;
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) write_word(int'($urandom_range(1, 65535)));
  endtask

  // One playback pass: start, optionally drop loop_en later, then compare the
  // strobe schedule, codes and done timing against the rule-derived model.
  task automatic play(input int div, input bit loop, input int drop_after,
                      input int first_wr, input bit wr_mid, input string tag);
    int ns, len, budget, c_drop, last, n;
    s_cyc.delete(); s_code.delete(); d_cyc.delete();
    clk_div = div[DW-1:0];
    loop_en = loop;
    if (first_wr >= 0) begin
      wr_en = 1'b1;
      wr_data = first_wr[15:0];
    end
    start = 1'b1;
    step();
    start = 1'b0;
    wr_en = 1'b0;
    if (first_wr >= 0) model_store(first_wr);
    ns = cyc;
    len = m_count;
    check({tag, "_busy_on"}, int'(busy), 1);
    c_drop = -1;
    budget = (loop ? drop_after : 0) + 2 * (len + 1) * (div + 1) + 20;
    for (int i = 0; i < budget; i++) begin
      if (d_cyc.size() > 0) break;
      if (wr_mid && i == 1) begin
        wr_en = 1'b1;
        wr_data = 16'($urandom);
      end
      if (wr_mid && i == 2) begin
        wr_en = 1'b0;
        m_ovf = 1;
      end
      if (loop && i == drop_after) begin
        loop_en = 1'b0;
        c_drop = cyc;
      end
      step();
    end
    if (!loop) begin
      last = len - 1;
    end else begin
      // The wrap decision is taken on the edge that issues sample len-1 of a pass.
      last = len - 1;
      while (ns + 1 + last * (div + 1) <= c_drop) last += len;
    end
    check({tag, "_nstrobes"}, s_cyc.size(), last + 1);
    n = (s_cyc.size() < last + 1) ? s_cyc.size() : last + 1;
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_cyc%0d", tag, k), s_cyc[k] - ns, 2 + k * (div + 1));
      check($sformatf("%s_code%0d", tag, k), s_code[k], m_mem[k % len]);
    end
    check({tag, "_ndone"}, d_cyc.size(), 1);
    if (d_cyc.size() > 0)
      check({tag, "_done_cyc"}, d_cyc[0] - ns, 3 + last * (div + 1));
    check({tag, "_hold"}, int'(dac_code), m_mem[last % len]);
    check({tag, "_busy_off"}, int'(busy), 0);
    check({tag, "_ovf"}, int'(overflow), m_ovf);
  endtask

  initial begin
    int n, d;
    repeat (3) step();
    // Reset state.
    check("rst_code", int'(dac_code), 0);
    check("rst_strobe", int'(dac_strobe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_count", int'(buf_count), 0);
    check("rst_ovf", int'(overflow), 0);
    rst_n = 1'b1;
    step();

    // Directed single pass.
    write_word('h001);
    write_word('h3FF);
    write_word('h200);
    write_word('h155);
    check("single_count", int'(buf_count), 4);
    play(2, 1'b0, 0, -1, 1'b0, "single");
    // Same data again without reloading.
    play(0, 1'b0, 0, -1, 1'b0, "replay");

    // Directed loop: 3 words, strobe every cycle, then stop looping.
    do_clear();
    load_random(3);
    play(0, 1'b1, 10, -1, 1'b0, "loop");

    // Randomized single passes and looped passes.
    for (int t = 0; t < 6; t++) begin
      do_clear();
      n = $urandom_range(1, 8);
      load_random(n);
      check($sformatf("rnd%0d_count", t), int'(buf_count), m_count);
      play($urandom_range(0, 3), 1'b0, 0, -1, 1'b0, $sformatf("rnd%0d", t));
    end
    for (int t = 0; t < 4; t++) begin
      do_clear();
      load_random($urandom_range(1, 4));
      play($urandom_range(0, 2), 1'b1, $urandom_range(3, 20), -1, 1'b0,
           $sformatf("rloop%0d", t));
    end

    // Start on an empty buffer together with the first write.
    do_clear();
    play(1, 1'b0, 0, $urandom_range(1, 1023), 1'b0, "wrstart");

    // Empty buffer: start ignored.
    do_clear();
    start = 1'b1;
    step();
    start = 1'b0;
    check("empty_busy0", int'(busy), 0);
    step();
    check("empty_busy1", int'(busy), 0);

    // Write during play is rejected; replay proves contents unchanged.
    do_clear();
    load_random(4);
    play(1, 1'b0, 0, -1, 1'b1, "wrplay");
    check("wrplay_count", int'(buf_count), 4);
    play(1, 1'b0, 0, -1, 1'b0, "wrplay_rep");

    // Overflow on the 1025th word, then clear.
    do_clear();
    load_random(DEPTH + 1);
    check("ovf_count", int'(buf_count), m_count);
    check("ovf_flag", int'(overflow), m_ovf);
    do_clear();
    check("clr_count", int'(buf_count), 0);
    check("clr_ovf", int'(overflow), 0);

    // Stop after the second strobe.
    load_random(4);
    s_cyc.delete(); s_code.delete(); d_cyc.delete();
    clk_div = 16'd9;
    loop_en = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 100 && s_cyc.size() < 2; i++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_busy", int'(busy), 0);
    repeat (40) step();
    check("stop_nstrobes", s_cyc.size(), 2);
    check("stop_ndone", d_cyc.size(), 0);
    check("stop_hold", int'(dac_code), m_mem[1]);

    // Asynchronous reset in the middle of a looped pass.
    do_clear();
    load_random(5);
    clk_div = 16'd1;
    loop_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_code", int'(dac_code), 0);
    check("arst_strobe", int'(dac_strobe), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_count", int'(buf_count), 0);
    check("arst_ovf", int'(overflow), 0);
    step();
    step();
    rst_n = 1'b1;
    loop_en = 1'b0;
    m_count = 0;
    m_wr = 0;
    m_ovf = 0;
    step();
    check("post_rst_count", int'(buf_count), 0);
    check("post_rst_busy", int'(busy), 0);
    d = $urandom_range(1, 1023);
    write_word(d);
    play(0, 1'b0, 0, -1, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
